vga_layer_ctrl: RTL and testbench
=================================

# vga_layer_ctrl

Per-pixel layer controller that feeds the enable and background inputs of the VGA output mux. Holds host-writable overlay configuration in shadow registers and commits it atomically at the start of vertical blanking, so a frame never tears. It generates the registered `map_en`, `debug_en` and `bg_rgb` signals and the map-local pixel coordinates, plus a delayed `visible`, all aligned one cycle behind the incoming scan position.

## Interface
- `H_VIS`, 640: visible pixels per line.
- `V_VIS`, 480: visible lines per frame; commit line.
- `MAP_W`, 128: map overlay width in pixels (power of two).
- `MAP_H`, 128: map overlay height in lines (power of two).
- `DBG_ROWS`, 16: height of the debug strip at the top of the frame.
- `BLINK_BIT`, 4: frame-counter bit that gates debug blinking.

- `clk` in 1: pixel clock; all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `hpos` in 10: current horizontal scan position.
- `vpos` in 10: current vertical scan position.
- `visible` in 1: current position is in the active area.
- `cfg_valid` in 1: host write request.
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_addr` in 3: register address.
- `cfg_data` in 10: write data; narrower registers use the low bits.
- `visible_q` out 1: `visible` delayed one cycle.
- `map_en` out 1: pixel lies in the enabled map window.
- `map_col` out log2(MAP_W): `hpos - map_x0`, truncated.
- `map_row` out log2(MAP_H): `vpos - map_y0`, truncated.
- `debug_en` out 1: pixel lies in the debug strip and the strip is shown.
- `bg_rgb` out 6: sky or floor colour, RRGGBB.
- `frame_tick` out 1: one-cycle pulse on every commit.

## Operation
- Register map. Each register has a shadow copy and an active copy.
  - 0 `map_x0`: 10 bits.
  - 1 `map_y0`: 10 bits.
  - 2 `flags`: bit0 `map_on`, bit1 `dbg_on`, bit2 `dbg_blink`.
  - 3 `sky_rgb`: 6 bits.
  - 4 `floor_rgb`: 6 bits.
  - Addresses 5–7 accept the write and have no effect.
- Writes update only the shadow copy. Repeated writes before a commit: the last one wins.
- Commit point is `hpos==0 && vpos==V_VIS`.
  - All shadow registers are copied to active in that single cycle.
  - `frame_cnt` (6 bits) increments and wraps 63→0.
  - `frame_tick` is asserted.
- `cfg_ready` is 0 during the commit cycle and 1 at all other times out of reset. A write presented during commit stalls one cycle, then lands in the shadow copy for the next frame.
- Output computation, from active registers only:
  - `map_en`: `map_on`, and `hpos` in [map_x0, map_x0+MAP_W), and `vpos` in [map_y0, map_y0+MAP_H). Compare with 11-bit sums so a window past 1023 clips and never wraps to column/row 0.
  - `debug_en`: `dbg_on && vpos < DBG_ROWS && (!dbg_blink || !frame_cnt[BLINK_BIT])`.
  - `bg_rgb`: `sky_rgb` if `vpos < V_VIS/2`, else `floor_rgb`.
- Outputs are not masked by `visible`; the mux does that with `visible_q`.

## Timing
- Every output is registered. Latency from `hpos`/`vpos`/`visible` to the corresponding output is 1 cycle.
- On reset (`reset_n` low at a clock edge):
  - Shadow and active: `map_x0=0`, `map_y0=0`, `flags=0`, `sky_rgb=6'b000011`, `floor_rgb=6'b010101`.
  - `frame_cnt=0`.
  - All outputs 0, including `cfg_ready`. `cfg_ready` rises the first cycle after `reset_n` goes high.
- Reset wins over a commit or write in the same cycle. Reset mid-frame discards pending shadow writes.
- Active registers change only at the commit point. The first pixel of the next frame uses the new values.
- A write accepted in the cycle before the commit cycle is included in that commit.

## Test plan
- Reset, then idle to `vpos=0`: `map_en=0`, `debug_en=0`, `bg_rgb=000011` for lines 0–239 and `010101` for lines 240+; `cfg_ready=1`.
- Write `map_x0=100`, `map_y0=50`, `flags=1` mid-frame: no `map_en` in the current frame. Next frame: `map_en=1` exactly at `hpos` 100–227, `vpos` 50–177 (seen one cycle later); `map_col=0` at `hpos=100`, `map_row=127` at `vpos=177`.
- Write `map_x0=960`: `map_en` only for `hpos` 960–1023; no assertion at low `hpos`.
- Present `cfg_valid` at the commit cycle: `cfg_ready=0` that cycle, accepted the next cycle, value visible only after the following commit; `frame_tick` is one cycle wide.
- `flags=6`: `debug_en=1` on lines 0–15 for frames where `frame_cnt[4]=0`, and 0 for the next 16 frames; period 32 frames.
- Assert `reset_n=0` mid-frame after shadow writes: all outputs 0 the next cycle, and the defaults are restored in both copies.

Source files
------------

// File: rtl/vga_layer_ctrl_if.sv
// Host configuration write channel for vga_layer_ctrl.
// valid/ready handshake; a write lands when both are high at a clock edge.
interface vga_layer_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_addr;
  logic [9:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/vga_layer_ctrl.sv
// Per-pixel layer controller: shadow/active overlay config committed at the start of
// vertical blanking, and registered map/debug/background outputs one cycle behind the scan.
module vga_layer_ctrl #(
  parameter int unsigned H_VIS     = 640,
  parameter int unsigned V_VIS     = 480,
  parameter int unsigned MAP_W     = 128,
  parameter int unsigned MAP_H     = 128,
  parameter int unsigned DBG_ROWS  = 16,
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [9:0]                 i_hpos,
  input  logic [9:0]                 i_vpos,
  input  logic                       i_visible,
  vga_layer_ctrl_if.slave            cfg,
  output logic                       o_visible_q,
  output logic                       o_map_en,
  output logic [$clog2(MAP_W)-1:0]   o_map_col,
  output logic [$clog2(MAP_H)-1:0]   o_map_row,
  output logic                       o_debug_en,
  output logic [5:0]                 o_bg_rgb,
  output logic                       o_frame_tick
);

  localparam int unsigned COL_W = $clog2(MAP_W);
  localparam int unsigned ROW_W = $clog2(MAP_H);

  localparam logic [5:0] SKY_RST   = 6'b000011;
  localparam logic [5:0] FLOOR_RST = 6'b010101;

  if (MAP_W > H_VIS) begin : g_map_w_chk
    $error("MAP_W must not exceed H_VIS");
  end

  logic [9:0] r_sh_x0, r_sh_y0, r_act_x0, r_act_y0;
  logic [2:0] r_sh_flags, r_act_flags;
  logic [5:0] r_sh_sky, r_sh_floor, r_act_sky, r_act_floor;
  logic [5:0] r_frame_cnt;
  logic       r_ready_en;

  logic                r_visible_q, r_map_en, r_debug_en, r_frame_tick;
  logic [COL_W-1:0]    r_map_col;
  logic [ROW_W-1:0]    r_map_row;
  logic [5:0]          r_bg_rgb;

  logic        w_commit, w_ready, w_accept;
  logic [10:0] w_x_end, w_y_end;
  logic        w_in_x, w_in_y, w_blink_off;

  assign w_commit = (i_hpos == 10'd0) && (i_vpos == 10'(V_VIS));
  assign w_ready  = r_ready_en & ~w_commit;
  assign w_accept = cfg.cfg_valid & w_ready;
  assign cfg.cfg_ready = w_ready;

  // 11-bit window ends so a window past column/row 1023 clips instead of wrapping.
  assign w_x_end = {1'b0, r_act_x0} + 11'(MAP_W);
  assign w_y_end = {1'b0, r_act_y0} + 11'(MAP_H);
  assign w_in_x  = (i_hpos >= r_act_x0) && ({1'b0, i_hpos} < w_x_end);
  assign w_in_y  = (i_vpos >= r_act_y0) && ({1'b0, i_vpos} < w_y_end);

  assign w_blink_off = r_act_flags[2] & r_frame_cnt[BLINK_BIT];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ready_en  <= 1'b0;
      r_sh_x0     <= '0;
      r_sh_y0     <= '0;
      r_sh_flags  <= '0;
      r_sh_sky    <= SKY_RST;
      r_sh_floor  <= FLOOR_RST;
      r_act_x0    <= '0;
      r_act_y0    <= '0;
      r_act_flags <= '0;
      r_act_sky   <= SKY_RST;
      r_act_floor <= FLOOR_RST;
      r_frame_cnt <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        case (cfg.cfg_addr)
          3'd0:    r_sh_x0    <= cfg.cfg_data;
          3'd1:    r_sh_y0    <= cfg.cfg_data;
          3'd2:    r_sh_flags <= cfg.cfg_data[2:0];
          3'd3:    r_sh_sky   <= cfg.cfg_data[5:0];
          3'd4:    r_sh_floor <= cfg.cfg_data[5:0];
          default: ;
        endcase
      end
      // No write can land in the commit cycle, so shadow is stable here.
      if (w_commit) begin
        r_act_x0    <= r_sh_x0;
        r_act_y0    <= r_sh_y0;
        r_act_flags <= r_sh_flags;
        r_act_sky   <= r_sh_sky;
        r_act_floor <= r_sh_floor;
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_visible_q  <= 1'b0;
      r_map_en     <= 1'b0;
      r_map_col    <= '0;
      r_map_row    <= '0;
      r_debug_en   <= 1'b0;
      r_bg_rgb     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_visible_q  <= i_visible;
      r_map_en     <= r_act_flags[0] & w_in_x & w_in_y;
      r_map_col    <= COL_W'(i_hpos - r_act_x0);
      r_map_row    <= ROW_W'(i_vpos - r_act_y0);
      r_debug_en   <= r_act_flags[1] & (i_vpos < 10'(DBG_ROWS)) & ~w_blink_off;
      r_bg_rgb     <= (i_vpos < 10'(V_VIS / 2)) ? r_act_sky : r_act_floor;
      r_frame_tick <= w_commit;
    end
  end

  assign o_visible_q  = r_visible_q;
  assign o_map_en     = r_map_en;
  assign o_map_col    = r_map_col;
  assign o_map_row    = r_map_row;
  assign o_debug_en   = r_debug_en;
  assign o_bg_rgb     = r_bg_rgb;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_layer_ctrl.sv
// Bench for vga_layer_ctrl: directed scenarios plus random scan/config traffic,
// every cycle compared against a register-map model of the controller.
module tb_vga_layer_ctrl;

  localparam int V_VIS = 480;
  localparam int MAP_W = 128;
  localparam int MAP_H = 128;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       visible = 1'b0;
  logic       visible_q, map_en, debug_en, frame_tick;
  logic [6:0] map_col, map_row;
  logic [5:0] bg_rgb;

  vga_layer_ctrl_if cfg_if ();

  vga_layer_ctrl dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_visible    (visible),
    .cfg          (cfg_if),
    .o_visible_q  (visible_q),
    .o_map_en     (map_en),
    .o_map_col    (map_col),
    .o_map_row    (map_row),
    .o_debug_en   (debug_en),
    .o_bg_rgb     (bg_rgb),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Register file model: index = register address; 0 x0, 1 y0, 2 flags, 3 sky, 4 floor.
  int  sh[5];
  int  ac[5];
  int  fcnt;
  bit  ready_en;
  bit  seen_edge;
  bit  last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int reg_mask(input int a);
    case (a)
      0, 1:    return 1023;
      2:       return 7;
      default: return 63;
    endcase
  endfunction

  task automatic model_reset();
    sh = '{0, 0, 0, 3, 21};
    ac = '{0, 0, 0, 3, 21};
    fcnt = 0;
    ready_en = 1'b0;
  endtask

  task automatic cycle(input int h, input int v, input bit vis, input bit val,
                       input int a, input int d, input bit rn);
    int e_map, e_col, e_row, e_dbg, e_bg, e_tick, e_vis;
    bit commit, acc;
    e_map = 0; e_col = 0; e_row = 0; e_dbg = 0; e_bg = 0; e_tick = 0; e_vis = 0;
    acc = 1'b0;
    hpos = 10'(h);
    vpos = 10'(v);
    visible = vis;
    cfg_if.cfg_valid = val;
    cfg_if.cfg_addr  = 3'(a);
    cfg_if.cfg_data  = 10'(d);
    reset_n = rn;
    commit = (h == 0) && (v == V_VIS);
    #1;
    if (seen_edge) chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(ready_en && !commit));
    @(posedge clk);
    seen_edge = 1'b1;
    if (!rn) begin
      model_reset();
    end else begin
      e_map = ((ac[2] & 1) != 0) && h >= ac[0] && h < ac[0] + MAP_W
              && v >= ac[1] && v < ac[1] + MAP_H;
      e_col = (h - ac[0]) & (MAP_W - 1);
      e_row = (v - ac[1]) & (MAP_H - 1);
      e_dbg = ((ac[2] & 2) != 0) && v < 16 && (((ac[2] & 4) == 0) || ((fcnt / 16) % 2 == 0));
      e_bg  = (v < V_VIS / 2) ? ac[3] : ac[4];
      e_tick = commit;
      e_vis  = vis;
      acc = val && ready_en && !commit;
      if (acc && a < 5) sh[a] = d & reg_mask(a);
      if (commit) begin
        ac = sh;
        fcnt = (fcnt + 1) % 64;
      end
      ready_en = 1'b1;
    end
    last_acc = acc;
    #1;
    chk("visible_q",  32'(visible_q),  32'(e_vis));
    chk("map_en",     32'(map_en),     32'(e_map));
    chk("map_col",    32'(map_col),    32'(e_col));
    chk("map_row",    32'(map_row),    32'(e_row));
    chk("debug_en",   32'(debug_en),   32'(e_dbg));
    chk("bg_rgb",     32'(bg_rgb),     32'(e_bg));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic step(input int h, input int v);
    cycle(h, v, (h < 640 && v < V_VIS), 1'b0, 0, 0, 1'b1);
  endtask

  task automatic commit_frame();
    cycle(0, V_VIS, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic wr(input int a, input int d);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 4 && !done; t++) begin
      cycle(300, 100, 1'b1, 1'b1, a, d, 1'b1);
      done = last_acc;
    end
    chk("wr_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, v;
    model_reset();
    seen_edge = 1'b0;
    last_acc = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_data  = '0;

    repeat (3) cycle(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Idle frame: defaults
    step(0, 0); step(639, 0); step(100, 239); step(100, 240); step(5, 479);

    // Map window at (100,50), written mid-frame
    wr(0, 100); wr(1, 50); wr(2, 1);
    step(100, 50); step(150, 100); step(227, 177);
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      int vs[4];
      vs = '{49, 50, 177, 178};
      foreach (vs[j]) begin
        step(99 + i, vs[j]);
        step(227 + i, vs[j]);
      end
    end

    // Window past the right edge clips
    wr(0, 960);
    commit_frame();
    step(959, 60); step(960, 60); step(1023, 60); step(0, 60); step(31, 60); step(5, 100);

    // Write presented at the commit cycle stalls one cycle
    cycle(0, V_VIS, 1'b0, 1'b1, 0, 7, 1'b1);
    cycle(1, V_VIS, 1'b0, 1'b1, 0, 7, 1'b1);
    step(970, 60); step(7, 60);
    commit_frame();
    step(7, 60); step(970, 60);

    // Write in the cycle right before commit joins that commit
    cycle(1023, V_VIS - 1, 1'b0, 1'b1, 3, 42, 1'b1);
    commit_frame();
    step(10, 10);

    // Debug strip blinking over 40 frames
    wr(2, 6);
    for (int f = 0; f < 40; f++) begin
      commit_frame();
      step(10, 0); step(10, 15); step(10, 16);
    end

    // Reset mid-frame after pending writes
    wr(0, 200); wr(3, 9); wr(2, 3);
    cycle(50, 50, 1'b1, 1'b0, 0, 0, 1'b0);
    cycle(50, 50, 1'b1, 1'b0, 0, 0, 1'b1);
    commit_frame();
    step(200, 10); step(0, 0); step(0, 300);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        h = 0; v = V_VIS;
      end else if (r < 50) begin
        h = (ac[0] + int'($urandom_range(0, 140)) - 6) & 1023;
        v = (ac[1] + int'($urandom_range(0, 140)) - 6) & 1023;
      end else begin
        h = int'($urandom_range(0, 1023));
        v = int'($urandom_range(0, 1023));
      end
      cycle(h, v, 1'($urandom), ($urandom_range(0, 99) < 25), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1023)), ($urandom_range(0, 199) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
